seq_feed_ctrl: RTL and testbench
================================

Name: seq_feed_ctrl

Overview:
Controller that sequences a serial sequence-detector FSM (the `w`/`z` Moore detector with `Clock`/`Reset` and a 4-bit state output).
- Clears the detector, then feeds it a stored pattern one bit at a time at a programmable rate.
- Samples the detector's `z` after every step and counts hits.
- Replaces manual KEY-clocking on the board: the top level drives the detector's `w`, clock-enable and reset from this block and shows `hits` on HEX/LEDR.

Parameters:
PAT_W, 16, maximum pattern length in bits
DIV_W, 26, width of rate divider counter
HIT_W, 8, width of hit counter

Ports:
Clock  in  1  system clock
Resetn  in  1  asynchronous active-low reset
start  in  1  level; sampled only in IDLE, launches a run
pattern  in  PAT_W  bit stream, LSB fed first
len  in  $clog2(PAT_W+1)  number of bits to feed
rate  in  DIV_W  extra wait cycles per bit (0 = fastest)
z_in  in  1  detector Moore output
w_out  out  1  serial bit to detector `w`
step  out  1  one-cycle detector clock enable
det_clr  out  1  one-cycle synchronous reset to detector
busy  out  1  high from CLEAR through last SAMPLE
done  out  1  one-cycle pulse at end of run
hits  out  HIT_W  number of sampled z_in==1, saturating

Behaviour:
- Reset (Resetn=0, async): state=IDLE; w_out=0, step=0, det_clr=0, busy=0, done=0, hits=0; bit index, divider and captured regs cleared.
- States: IDLE, CLEAR, WAIT, STEP, SAMPLE, DONE.
- IDLE: if start=1 at a Clock edge:
  - Capture pattern, len and rate.
  - Clamp len>PAT_W to PAT_W.
  - Clear hits and bit index.
  - Go to CLEAR.
  - `start` is ignored in every other state.
- CLEAR: det_clr=1 for exactly one cycle; busy=1.
  - If captured len==0, go to DONE (no steps issued).
  - Otherwise go to WAIT.
- WAIT:
  - w_out = captured pattern[bit_idx], stable for the whole bit period.
  - Divider counts 0..rate; when count==rate go to STEP (rate=0 gives 1 WAIT cycle).
- STEP: step=1 for one cycle, w_out unchanged; the detector advances at the end of this cycle.
- SAMPLE:
  - Sample z_in, which reflects the new detector state.
  - If z_in=1, increment hits, holding at 2^HIT_W-1.
  - If bit_idx==len-1, go to DONE; otherwise increment bit_idx, clear the divider and go to WAIT.
- DONE: done=1 for one cycle, busy=0, go to IDLE. hits holds its value until the next start.
- Timing:
  - Per-bit period = rate+3 cycles.
  - Run length = 1 + len*(rate+3) cycles, plus the DONE cycle.
- w_out: 0 in IDLE and CLEAR; in DONE it keeps the last bit.
- Reset mid-run: abort immediately to IDLE with all outputs at reset values; no done pulse.
- Only one of step/det_clr/done is ever high in a given cycle.

Optional Feature:
Macro FEED_LOOP_EN.
- Defined:
  - Adds input `loop` (1 bit), sampled at start.
  - If `loop` was 1, SAMPLE of the last bit wraps bit_idx to 0 and returns to WAIT, with no det_clr, no done and hits continuing.
  - The run ends only when `loop` is observed 0 in a SAMPLE of the last bit, which then goes to DONE.
  - Detector state carries across wrap-around.
- Undefined: no `loop` port; every run is single-pass as above.

Decomposition:
- Package seq_ctrl_pkg: state encoding localparams (IDLE=3'd0, CLEAR=3'd1, WAIT=3'd2, STEP=3'd3, SAMPLE=3'd4, DONE=3'd5), default HIT_W.
- One sub-module: rate_divider (load/clear, count to `rate`, terminal-count pulse, DIV_W wide).
- FSM and datapath stay in seq_feed_ctrl.

Test Plan:
- Bench model: the team detector (A..G), with z=1 in states F and G.
- Reset: assert Resetn=0 mid-WAIT -> all outputs 0 on the same cycle, state IDLE; after release, no step or done until a new start.
- Basic run: pattern=16'h001F, len=5, rate=0, start pulse -> det_clr 1 cycle after capture; 5 step pulses 3 cycles apart; w_out 1,1,1,1,1; hits=2; done exactly 17 cycles after the start edge.
- Pattern 1101: pattern=16'h000B (LSB first 1,1,0,1), len=4, rate=2 -> detector path A-B-C-E-G; hits=1; step spacing 5 cycles; w_out stable across each WAIT.
- Edge cases:
  - len=0 -> det_clr then done, zero steps, hits=0.
  - len=31 -> clamped to 16 steps.
  - start held high through a run -> exactly one run, then an immediate second run after DONE.
- Saturation (HIT_W=2): pattern=16'hFFFF, len=16 -> hits stops at 3.
- FEED_LOOP_EN:
  - loop=1, pattern=16'h000F, len=4 -> after bit 3 the next step re-feeds bit 0 with no det_clr; hits keeps rising.
  - Drop loop -> done after the next last-bit SAMPLE.

Source files
------------

// File: rtl/seq_feed_ctrl_pkg.sv
// Shared state encoding and defaults for the sequence-feed controller.
package seq_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CLEAR  = 3'd1,
    WAIT   = 3'd2,
    STEP   = 3'd3,
    SAMPLE = 3'd4,
    DONE   = 3'd5
  } state_t;

  localparam int unsigned HIT_W_DEFAULT = 8;

endpackage

// File: rtl/seq_feed_ctrl_if.sv
// Run-control and detector-side signals of seq_feed_ctrl.
// Optional `loop` input exists only when FEED_LOOP_EN is defined.
interface seq_feed_ctrl_if
  import seq_ctrl_pkg::*;
#(
  parameter int unsigned PAT_W = 16,
  parameter int unsigned DIV_W = 26,
  parameter int unsigned HIT_W = HIT_W_DEFAULT
);
  localparam int unsigned LEN_W = $clog2(PAT_W + 1);

  logic             start;
  logic [PAT_W-1:0] pattern;
  logic [LEN_W-1:0] len;
  logic [DIV_W-1:0] rate;
  logic             z_in;
`ifdef FEED_LOOP_EN
  logic             loop;
`endif
  logic             w_out;
  logic             step;
  logic             det_clr;
  logic             busy;
  logic             done;
  logic [HIT_W-1:0] hits;

  modport master (
`ifdef FEED_LOOP_EN
    output loop,
`endif
    output start, pattern, len, rate, z_in,
    input  w_out, step, det_clr, busy, done, hits
  );

  modport slave (
`ifdef FEED_LOOP_EN
    input  loop,
`endif
    input  start, pattern, len, rate, z_in,
    output w_out, step, det_clr, busy, done, hits
  );

endinterface

// File: rtl/seq_feed_ctrl_rate_divider.sv
// Per-bit wait counter: counts 0..rate while enabled, tc marks count==rate.
module rate_divider #(
  parameter int unsigned DIV_W = 26
) (
  input  logic             Clock,
  input  logic             Resetn,
  input  logic             clr,
  input  logic             en,
  input  logic [DIV_W-1:0] rate,
  output logic             tc
);

  logic [DIV_W-1:0] cnt;

  assign tc = en && (cnt == rate);

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && !tc) begin
      cnt <= cnt + DIV_W'(1);
    end
  end

endmodule

// File: rtl/seq_feed_ctrl.sv
// Clears a serial sequence detector, feeds it a stored pattern LSB first and counts z hits.
// Build option FEED_LOOP_EN adds a `loop` input for continuous wrap-around feeding.
module seq_feed_ctrl
  import seq_ctrl_pkg::*;
#(
  parameter int unsigned PAT_W = 16,
  parameter int unsigned DIV_W = 26,
  parameter int unsigned HIT_W = HIT_W_DEFAULT
) (
  input  logic            Clock,
  input  logic            Resetn,
  seq_feed_ctrl_if.slave  bus
);

  localparam int unsigned      LEN_W   = $clog2(PAT_W + 1);
  localparam int unsigned      IDX_W   = (PAT_W > 1) ? $clog2(PAT_W) : 1;
  localparam logic [LEN_W-1:0] PAT_MAX = LEN_W'(PAT_W);

  state_t           state_q, state_d;
  logic [PAT_W-1:0] pattern_q;
  logic [LEN_W-1:0] len_q;
  logic [DIV_W-1:0] rate_q;
  logic [IDX_W-1:0] bit_idx;
  logic [HIT_W-1:0] hits_q;
  logic             div_clr, div_en, div_tc;
  logic             last_bit, wrap;

  assign last_bit = (LEN_W'(bit_idx) == len_q - LEN_W'(1));

`ifdef FEED_LOOP_EN
  logic loop_q;
  // Looping needs both the captured request and the live input still high.
  assign wrap = loop_q && bus.loop;
`else
  assign wrap = 1'b0;
`endif

  assign div_clr = (state_q == CLEAR) || (state_q == SAMPLE);
  assign div_en  = (state_q == WAIT);

  rate_divider #(.DIV_W(DIV_W)) u_div (
    .Clock  (Clock),
    .Resetn (Resetn),
    .clr    (div_clr),
    .en     (div_en),
    .rate   (rate_q),
    .tc     (div_tc)
  );

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = CLEAR;
      CLEAR:   state_d = (len_q == '0) ? DONE : WAIT;
      WAIT:    if (div_tc) state_d = STEP;
      STEP:    state_d = SAMPLE;
      SAMPLE:  state_d = (last_bit && !wrap) ? DONE : WAIT;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      pattern_q <= '0;
      len_q     <= '0;
      rate_q    <= '0;
      bit_idx   <= '0;
      hits_q    <= '0;
`ifdef FEED_LOOP_EN
      loop_q    <= 1'b0;
`endif
    end else begin
      if (state_q == IDLE && bus.start) begin
        pattern_q <= bus.pattern;
        len_q     <= (bus.len > PAT_MAX) ? PAT_MAX : bus.len;
        rate_q    <= bus.rate;
        bit_idx   <= '0;
        hits_q    <= '0;
`ifdef FEED_LOOP_EN
        loop_q    <= bus.loop;
`endif
      end
      if (state_q == SAMPLE) begin
        if (bus.z_in && (hits_q != '1)) hits_q <= hits_q + HIT_W'(1);
        if (!last_bit)  bit_idx <= bit_idx + IDX_W'(1);
        else if (wrap)  bit_idx <= '0;
      end
    end
  end

  // Outputs decode straight from state so an async reset clears them in the same cycle.
  assign bus.det_clr = (state_q == CLEAR);
  assign bus.step    = (state_q == STEP);
  assign bus.done    = (state_q == DONE);
  assign bus.busy    = (state_q == CLEAR) || (state_q == WAIT) ||
                       (state_q == STEP)  || (state_q == SAMPLE);
  assign bus.hits    = hits_q;
  assign bus.w_out   = ((state_q == IDLE) || (state_q == CLEAR) ||
                        ((state_q == DONE) && (len_q == '0))) ? 1'b0 : pattern_q[bit_idx];

endmodule

// File: tb/tb_seq_feed_ctrl.sv
// Directed bench for seq_feed_ctrl with a behavioural A..G detector (z=1 in F and G).
module tb_seq_feed_ctrl;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic [15:0] pattern = '0;
  logic [4:0]  len = '0;
  logic [25:0] rate = '0;
`ifdef FEED_LOOP_EN
  logic        loop = 1'b0;
`endif

  always #5 clk = ~clk;

  seq_feed_ctrl_if #(.PAT_W(16), .DIV_W(26), .HIT_W(8)) bus ();
  seq_feed_ctrl_if #(.PAT_W(16), .DIV_W(26), .HIT_W(2)) bus2 ();

  assign bus.start    = start;
  assign bus.pattern  = pattern;
  assign bus.len      = len;
  assign bus.rate     = rate;
  assign bus2.start   = start;
  assign bus2.pattern = pattern;
  assign bus2.len     = len;
  assign bus2.rate    = rate;
`ifdef FEED_LOOP_EN
  assign bus.loop     = loop;
  assign bus2.loop    = loop;
`endif

  seq_feed_ctrl #(.PAT_W(16), .DIV_W(26), .HIT_W(8)) dut (
    .Clock(clk), .Resetn(rst_n), .bus(bus));
  seq_feed_ctrl #(.PAT_W(16), .DIV_W(26), .HIT_W(2)) dut_sat (
    .Clock(clk), .Resetn(rst_n), .bus(bus2));

  // Detector model: F = four 1s seen, G = 1101 seen.
  typedef enum logic [2:0] {S_A, S_B, S_C, S_D, S_E, S_F, S_G} det_t;
  det_t det1, det2;

  function automatic det_t det_next(det_t s, logic w);
    case (s)
      S_A:     return w ? S_B : S_A;
      S_B:     return w ? S_C : S_A;
      S_C:     return w ? S_D : S_E;
      S_D:     return w ? S_F : S_E;
      S_E:     return w ? S_G : S_A;
      S_F:     return w ? S_F : S_E;
      default: return w ? S_B : S_A;
    endcase
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)            det1 <= S_A;
    else if (bus.det_clr)  det1 <= S_A;
    else if (bus.step)     det1 <= det_next(det1, bus.w_out);
  end
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)            det2 <= S_A;
    else if (bus2.det_clr) det2 <= S_A;
    else if (bus2.step)    det2 <= det_next(det2, bus2.w_out);
  end
  assign bus.z_in  = (det1 == S_F) || (det1 == S_G);
  assign bus2.z_in = (det2 == S_F) || (det2 == S_G);

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  int unsigned done_cyc, n_clr, clr_cyc, n_step, n_overlap;
  logic [7:0]  hits_at_done;
  logic [1:0]  hits2_at_done;
  int unsigned step_cyc[$];
  logic        w_hist[$];
  logic        busy_hist[$];

  // Expected w_out in cycle c of a run (cycle 1 = CLEAR, dc = DONE cycle).
  function automatic logic exp_w(logic [15:0] p, int unsigned l, int unsigned per,
                                 int unsigned c, int unsigned dc);
    int unsigned lc;
    lc = (l > 16) ? 16 : l;
    if (c <= 1) return 1'b0;
    if (c >= dc) return (lc == 0) ? 1'b0 : p[lc-1];
    return p[((c - 2) / per) % lc];
  endfunction

  task automatic launch(input logic [15:0] p, input logic [4:0] l,
                        input logic [25:0] r, input logic hold);
    @(negedge clk);
    pattern = p; len = l; rate = r; start = 1'b1;
    @(negedge clk);
    if (!hold) start = 1'b0;
  endtask

  // Called at the negedge of cycle 1; returns at the negedge of the DONE cycle.
  task automatic observe_run(input int unsigned budget);
    done_cyc = 0; n_clr = 0; clr_cyc = 0; n_step = 0; n_overlap = 0;
    hits_at_done = '0; hits2_at_done = '0;
    step_cyc.delete(); w_hist.delete(); busy_hist.delete();
    w_hist.push_back(1'b0); busy_hist.push_back(1'b0);
    for (int unsigned c = 1; c <= budget; c++) begin
      w_hist.push_back(bus.w_out);
      busy_hist.push_back(bus.busy);
      if (bus.det_clr) begin n_clr++; clr_cyc = c; end
      if (bus.step) begin n_step++; step_cyc.push_back(c); end
      if (int'(bus.step) + int'(bus.det_clr) + int'(bus.done) > 1) n_overlap++;
      if (bus.done) begin
        done_cyc = c; hits_at_done = bus.hits; hits2_at_done = bus2.hits;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    int unsigned seen;
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({bus.step, bus.det_clr, bus.done, bus.busy, bus.w_out} !== 5'b0) begin
      n_fail++; $display("FAIL reset_ctrl_outputs: got %b expected 00000",
        {bus.step, bus.det_clr, bus.done, bus.busy, bus.w_out});
    end
    n_checks++;
    if (bus.hits !== 8'd0 || bus2.hits !== 2'd0) begin
      n_fail++; $display("FAIL reset_hits: got %0d/%0d expected 0/0", bus.hits, bus2.hits);
    end
    @(negedge clk); rst_n = 1'b1;
    launch(16'h001F, 5'd5, 26'd3, 1'b0);
    @(negedge clk); @(negedge clk);
    n_checks++;
    if ({bus.busy, bus.w_out} !== 2'b11) begin
      n_fail++; $display("FAIL reset_pre_wait: got busy,w=%b expected 11", {bus.busy, bus.w_out});
    end
    #1 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({bus.step, bus.det_clr, bus.done, bus.busy, bus.w_out, bus.hits} !== 13'b0) begin
      n_fail++; $display("FAIL reset_mid_wait: got %b expected all zero",
        {bus.step, bus.det_clr, bus.done, bus.busy, bus.w_out, bus.hits});
    end
    n_checks++;
    if (dut.state_q !== seq_ctrl_pkg::IDLE) begin
      n_fail++; $display("FAIL reset_state: got %0d expected %0d", dut.state_q, seq_ctrl_pkg::IDLE);
    end
    @(negedge clk); rst_n = 1'b1;
    seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (bus.step || bus.done || bus.busy || bus.det_clr) seen++;
    end
    n_checks++;
    if (seen !== 0) begin
      n_fail++; $display("FAIL reset_quiet_after: got %0d active cycles expected 0", seen);
    end
  endtask

  task automatic test_basic();
    int unsigned errs;
    launch(16'h001F, 5'd5, 26'd0, 1'b0);
    observe_run(40);
    n_checks++;
    if (done_cyc !== 17) begin
      n_fail++; $display("FAIL basic_done_cycle: got %0d expected 17", done_cyc);
    end
    n_checks++;
    if (n_clr !== 1 || clr_cyc !== 1) begin
      n_fail++; $display("FAIL basic_det_clr: got count %0d at %0d expected 1 at 1", n_clr, clr_cyc);
    end
    n_checks++;
    if (n_step !== 5) begin
      n_fail++; $display("FAIL basic_step_count: got %0d expected 5", n_step);
    end
    errs = 0;
    foreach (step_cyc[k]) if (step_cyc[k] != 3 + 3 * k) errs++;
    n_checks++;
    if (errs !== 0) begin
      n_fail++; $display("FAIL basic_step_spacing: got %0d misplaced expected 0", errs);
    end
    errs = 0;
    for (int unsigned c = 1; c < w_hist.size(); c++)
      if (w_hist[c] !== exp_w(16'h001F, 5, 3, c, done_cyc)) errs++;
    n_checks++;
    if (errs !== 0) begin
      n_fail++; $display("FAIL basic_w_out: got %0d bad cycles expected 0", errs);
    end
    errs = 0;
    for (int unsigned c = 1; c < busy_hist.size(); c++)
      if (busy_hist[c] !== (c < done_cyc)) errs++;
    n_checks++;
    if (errs !== 0) begin
      n_fail++; $display("FAIL basic_busy: got %0d bad cycles expected 0", errs);
    end
    n_checks++;
    if (hits_at_done !== 8'd2 || hits2_at_done !== 2'd2) begin
      n_fail++; $display("FAIL basic_hits: got %0d/%0d expected 2/2", hits_at_done, hits2_at_done);
    end
    n_checks++;
    if (n_overlap !== 0) begin
      n_fail++; $display("FAIL basic_pulse_overlap: got %0d expected 0", n_overlap);
    end
    repeat (3) @(negedge clk);
    n_checks++;
    if (bus.hits !== 8'd2 || bus.done !== 1'b0) begin
      n_fail++; $display("FAIL basic_hits_hold: got hits %0d done %b expected 2 0", bus.hits, bus.done);
    end
  endtask

  task automatic test_pattern_1101();
    int unsigned errs;
    launch(16'h000B, 5'd4, 26'd2, 1'b0);
    observe_run(60);
    n_checks++;
    if (done_cyc !== 22 || n_step !== 4) begin
      n_fail++; $display("FAIL p1101_timing: got done %0d steps %0d expected 22 4", done_cyc, n_step);
    end
    errs = 0;
    foreach (step_cyc[k]) if (step_cyc[k] != 5 + 5 * k) errs++;
    n_checks++;
    if (errs !== 0) begin
      n_fail++; $display("FAIL p1101_step_spacing: got %0d misplaced expected 0", errs);
    end
    errs = 0;
    for (int unsigned c = 1; c < w_hist.size(); c++)
      if (w_hist[c] !== exp_w(16'h000B, 4, 5, c, done_cyc)) errs++;
    n_checks++;
    if (errs !== 0) begin
      n_fail++; $display("FAIL p1101_w_out: got %0d bad cycles expected 0", errs);
    end
    n_checks++;
    if (hits_at_done !== 8'd1) begin
      n_fail++; $display("FAIL p1101_hits: got %0d expected 1", hits_at_done);
    end
  endtask

  task automatic test_len_zero();
    launch(16'hFFFF, 5'd0, 26'd0, 1'b0);
    observe_run(10);
    n_checks++;
    if (done_cyc !== 2 || n_clr !== 1 || n_step !== 0) begin
      n_fail++; $display("FAIL len0_run: got done %0d clr %0d steps %0d expected 2 1 0",
        done_cyc, n_clr, n_step);
    end
    n_checks++;
    if (hits_at_done !== 8'd0 || w_hist[w_hist.size()-1] !== 1'b0) begin
      n_fail++; $display("FAIL len0_hits_w: got hits %0d w %b expected 0 0",
        hits_at_done, w_hist[w_hist.size()-1]);
    end
  endtask

  task automatic test_len_clamp();
    int unsigned errs;
    launch(16'h00FF, 5'd31, 26'd0, 1'b0);
    observe_run(120);
    n_checks++;
    if (n_step !== 16 || done_cyc !== 50) begin
      n_fail++; $display("FAIL clamp_steps: got steps %0d done %0d expected 16 50", n_step, done_cyc);
    end
    errs = 0;
    for (int unsigned c = 1; c < w_hist.size(); c++)
      if (w_hist[c] !== exp_w(16'h00FF, 31, 3, c, done_cyc)) errs++;
    n_checks++;
    if (errs !== 0 || hits_at_done !== 8'd5) begin
      n_fail++; $display("FAIL clamp_w_hits: got %0d bad w, hits %0d expected 0, 5", errs, hits_at_done);
    end
  endtask

  task automatic test_saturation();
    launch(16'hFFFF, 5'd16, 26'd0, 1'b0);
    observe_run(120);
    n_checks++;
    if (hits2_at_done !== 2'd3 || hits_at_done !== 8'd13 || done_cyc !== 50) begin
      n_fail++; $display("FAIL sat_hits: got %0d/%0d done %0d expected 3/13 done 50",
        hits2_at_done, hits_at_done, done_cyc);
    end
  endtask

  task automatic test_back_to_back();
    int unsigned seen;
    launch(16'h000F, 5'd1, 26'd0, 1'b1);
    observe_run(20);
    n_checks++;
    if (done_cyc !== 5 || n_clr !== 1) begin
      n_fail++; $display("FAIL b2b_first: got done %0d clr %0d expected 5 1", done_cyc, n_clr);
    end
    @(negedge clk);
    n_checks++;
    if ({bus.busy, bus.det_clr, bus.step} !== 3'b000) begin
      n_fail++; $display("FAIL b2b_idle_gap: got %b expected 000", {bus.busy, bus.det_clr, bus.step});
    end
    @(negedge clk);
    n_checks++;
    if (bus.det_clr !== 1'b1) begin
      n_fail++; $display("FAIL b2b_second_clr: got %b expected 1", bus.det_clr);
    end
    start = 1'b0;
    observe_run(20);
    n_checks++;
    if (done_cyc !== 5 || n_step !== 1) begin
      n_fail++; $display("FAIL b2b_second_run: got done %0d steps %0d expected 5 1", done_cyc, n_step);
    end
    seen = 0;
    repeat (4) begin
      @(negedge clk);
      if (bus.det_clr || bus.busy) seen++;
    end
    n_checks++;
    if (seen !== 0) begin
      n_fail++; $display("FAIL b2b_no_third: got %0d active cycles expected 0", seen);
    end
  endtask

`ifdef FEED_LOOP_EN
  task automatic test_loop();
    int unsigned errs;
    loop = 1'b1;
    launch(16'h000F, 5'd4, 26'd0, 1'b0);
    fork
      begin repeat (19) @(negedge clk); loop = 1'b0; end
      observe_run(80);
    join
    n_checks++;
    if (n_clr !== 1 || n_step !== 8 || done_cyc !== 26) begin
      n_fail++; $display("FAIL loop_run: got clr %0d steps %0d done %0d expected 1 8 26",
        n_clr, n_step, done_cyc);
    end
    errs = 0;
    for (int unsigned c = 1; c < w_hist.size(); c++)
      if (w_hist[c] !== exp_w(16'h000F, 4, 3, c, done_cyc)) errs++;
    n_checks++;
    if (errs !== 0 || hits_at_done !== 8'd5) begin
      n_fail++; $display("FAIL loop_w_hits: got %0d bad w, hits %0d expected 0, 5", errs, hits_at_done);
    end
  endtask
`endif

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_pattern_1101();
    test_len_zero();
    test_len_clamp();
    test_saturation();
    test_back_to_back();
`ifdef FEED_LOOP_EN
    test_loop();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
